// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way set-associative cache.
// Tags are stored zero-extended to the widest legal tag so the struct is geometry-independent.
package cache_pkg;

  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_BITS = 4;
  localparam int MAX_TAG_W   = ADDR_W - OFFSET_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } line_meta_t;

  function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_lru.sv
// Valid/tag/LRU storage for both ways, with combinational match and victim selection.
// Each set's LRU bit names the least-recently-used way.
module cache_tag_lru
  import cache_pkg::*;
#(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] lookupSet_i,
  input  logic [TAG_BITS-1:0] lookupTag_i,
  output logic                hitAny_o,
  output logic                hitWay_o,
  output logic                victimWay_o,
  input  logic                lruWrEn_i,
  input  logic [SET_BITS-1:0] lruWrSet_i,
  input  logic                lruWrVal_i,
  input  logic                installEn_i,
  input  logic [SET_BITS-1:0] installSet_i,
  input  logic                installWay_i,
  input  logic [TAG_BITS-1:0] installTag_i
);

  localparam int NUM_SETS = 1 << SET_BITS;

  line_meta_t meta_q [NUM_SETS][2];
  logic       lru_q  [NUM_SETS];

  line_meta_t way0;
  line_meta_t way1;
  logic       match0;
  logic       match1;

  assign way0   = meta_q[lookupSet_i][0];
  assign way1   = meta_q[lookupSet_i][1];
  assign match0 = way0.valid && (way0.tag == MAX_TAG_W'(lookupTag_i));
  assign match1 = way1.valid && (way1.tag == MAX_TAG_W'(lookupTag_i));

  // A double match cannot happen legally; way0 takes precedence if it ever does.
  assign hitAny_o = match0 || match1;
  assign hitWay_o = !match0;

  always_comb begin
    victimWay_o = lru_q[lookupSet_i];
    if (!way0.valid) begin
      victimWay_o = 1'b0;
    end else if (!way1.valid) begin
      victimWay_o = 1'b1;
    end
  end

  // Installing a line makes it most-recent, so the other way becomes LRU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s]     <= 1'b0;
        meta_q[s][0] <= '0;
        meta_q[s][1] <= '0;
      end
    end else begin
      if (installEn_i) begin
        meta_q[installSet_i][installWay_i] <= '{valid: 1'b1, tag: MAX_TAG_W'(installTag_i)};
        lru_q[installSet_i]                <= ~installWay_i;
      end else if (lruWrEn_i) begin
        lru_q[lruWrSet_i] <= lruWrVal_i;
      end
    end
  end

endmodule

// File: rtl/cache_2way_lru.sv
// Two-way set-associative write-through, write-allocate cache of 16-bit words.
// Hits answer combinationally; misses hand a block address to the arbiter and wait for its fill.
module cache_2way_lru
  import cache_pkg::*;
#(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        access_en,
  input  logic [15:0] addr,
  input  logic        write_en,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        hit,
  output logic        miss_detected,
  output logic [15:0] miss_addr,
  input  logic [15:0] fill_data,
  input  logic [15:0] fill_addr,
  input  logic        write_data_array,
  input  logic        write_tag_array
);

  localparam int NUM_SETS = 1 << SET_BITS;

  logic [SET_BITS-1:0] reqSet;
  logic [TAG_BITS-1:0] reqTag;
  logic [2:0]          reqWord;
  logic                unusedBits;

  assign reqSet     = addr[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign reqTag     = addr[ADDR_W-1:SET_BITS+OFFSET_BITS];
  assign reqWord    = addr[3:1];
  assign unusedBits = ^{addr[0], fill_addr[15:4], fill_addr[0]};

  cache_state_e        state_q,   state_d;
  logic [SET_BITS-1:0] fillSet_q, fillSet_d;
  logic [TAG_BITS-1:0] fillTag_q, fillTag_d;
  logic                fillWay_q, fillWay_d;

  logic hitAny;
  logic hitWay;
  logic victimWay;
  logic lruWrEn;
  logic lruWrVal;
  logic installEn;

  logic                dataWrEn;
  logic [SET_BITS-1:0] dataWrSet;
  logic                dataWrWay;
  logic [2:0]          dataWrWord;
  logic [WORD_W-1:0]   dataWrVal;

  logic [WORD_W-1:0] data_q [NUM_SETS][2][BLOCK_WORDS];

  cache_tag_lru #(
    .SET_BITS(SET_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_tagLru (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookupSet_i  (reqSet),
    .lookupTag_i  (reqTag),
    .hitAny_o     (hitAny),
    .hitWay_o     (hitWay),
    .victimWay_o  (victimWay),
    .lruWrEn_i    (lruWrEn),
    .lruWrSet_i   (reqSet),
    .lruWrVal_i   (lruWrVal),
    .installEn_i  (installEn),
    .installSet_i (fillSet_q),
    .installWay_i (fillWay_q),
    .installTag_i (fillTag_q)
  );

  assign hit       = access_en && hitAny;
  assign read_data = hit ? data_q[reqSet][hitWay][reqWord] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fillSet_q <= '0;
      fillTag_q <= '0;
      fillWay_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fillSet_q <= fillSet_d;
      fillTag_q <= fillTag_d;
      fillWay_q <= fillWay_d;
    end
  end

  // The fill target is frozen at miss time so the CPU may wander on addr during FILL.
  always_comb begin
    state_d       = state_q;
    fillSet_d     = fillSet_q;
    fillTag_d     = fillTag_q;
    fillWay_d     = fillWay_q;
    miss_detected = 1'b0;
    miss_addr     = '0;
    lruWrEn       = 1'b0;
    lruWrVal      = 1'b0;
    installEn     = 1'b0;
    dataWrEn      = 1'b0;
    dataWrSet     = reqSet;
    dataWrWay     = hitWay;
    dataWrWord    = reqWord;
    dataWrVal     = write_data;
    case (state_q)
      IDLE: begin
        if (access_en && !hitAny) begin
          miss_detected = 1'b1;
          miss_addr     = blockBase(addr);
          state_d       = FILL;
          fillSet_d     = reqSet;
          fillTag_d     = reqTag;
          fillWay_d     = victimWay;
        end else if (hit) begin
          lruWrEn  = 1'b1;
          lruWrVal = ~hitWay;
          dataWrEn = write_en;
        end
      end
      FILL: begin
        miss_detected = 1'b1;
        miss_addr     = {fillTag_q, fillSet_q, {OFFSET_BITS{1'b0}}};
        if (write_data_array) begin
          dataWrEn   = 1'b1;
          dataWrSet  = fillSet_q;
          dataWrWay  = fillWay_q;
          dataWrWord = fill_addr[3:1];
          dataWrVal  = fill_data;
        end
        if (write_tag_array) begin
          installEn = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dataWrEn) begin
      data_q[dataWrSet][dataWrWay][dataWrWord] <= dataWrVal;
    end
  end

endmodule
